// File: rtl/step_rate_ctrl.sv
// Commutation step scheduler: ramps the step period toward a commanded target and
// emits one-cycle step ticks plus a 6-state phase index for the 3-phase PWM stage.
module step_rate_ctrl #(
    parameter int unsigned WIDTH      = 18,
    parameter int unsigned MIN_PERIOD = 20000,
    parameter int unsigned MAX_PERIOD = 250000,
    parameter int unsigned RAMP_STEP  = 1000
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_period,
    input  logic             cmd_dir,
    output logic             step_tick,
    output logic             step_dir,
    output logic [2:0]       phase_idx,
    output logic             motor_en,
    output logic             at_speed,
    output logic [WIDTH-1:0] cur_period
);

    localparam logic [WIDTH-1:0] P_MIN   = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] P_MAX   = WIDTH'(MAX_PERIOD);
    localparam logic [WIDTH-1:0] P_RAMP  = WIDTH'(RAMP_STEP);
    localparam logic [2:0]       PH_LAST = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_REVERSE  = 2'd2,
        S_STOPPING = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_cur, w_cur_nxt;
    logic [WIDTH-1:0] r_tgt, w_tgt_nxt;
    logic [WIDTH-1:0] r_pend, w_pend_nxt;
    logic             r_pend_dir, w_pend_dir_nxt;
    logic             r_dir, w_dir_nxt;
    logic [2:0]       r_phase, w_phase_nxt;
    logic             r_tick, w_tick_nxt;
    logic             r_en, w_en_nxt;
    logic             r_at, w_at_nxt;

    logic             w_accept;
    logic             w_terminal;
    logic             w_same_dir;
    logic [WIDTH-1:0] w_clamped;
    logic [WIDTH-1:0] w_goal;
    logic [WIDTH-1:0] w_ramped;

    assign cmd_ready  = (r_state != S_REVERSE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_same_dir = (cmd_dir == r_dir);
    assign w_clamped  = (cmd_period < P_MIN) ? P_MIN :
                        (cmd_period > P_MAX) ? P_MAX : cmd_period;
    assign w_terminal = (r_state != S_IDLE) && (r_cnt == r_cur - WIDTH'(1));
    assign w_goal     = (r_state == S_RUN) ? r_tgt : P_MAX;

    // One ramp step toward the goal, saturating so the goal is never overshot.
    always_comb begin
        w_ramped = w_goal;
        if (r_cur < w_goal) begin
            if (w_goal - r_cur > P_RAMP) w_ramped = r_cur + P_RAMP;
        end else if (r_cur > w_goal) begin
            if (r_cur - w_goal > P_RAMP) w_ramped = r_cur - P_RAMP;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_nxt      = r_cur;
        w_tgt_nxt      = r_tgt;
        w_pend_nxt     = r_pend;
        w_pend_dir_nxt = r_pend_dir;
        w_dir_nxt      = r_dir;
        w_phase_nxt    = r_phase;
        w_tick_nxt     = 1'b0;

        if (r_state != S_IDLE) begin
            if (w_terminal) begin
                w_cnt_nxt  = '0;
                w_tick_nxt = 1'b1;
                w_cur_nxt  = w_ramped;
                if (!r_dir) w_phase_nxt = (r_phase == PH_LAST) ? 3'd0 : r_phase + 3'd1;
                else        w_phase_nxt = (r_phase == 3'd0) ? PH_LAST : r_phase - 3'd1;
            end else begin
                w_cnt_nxt = r_cnt + WIDTH'(1);
            end
        end

        unique case (r_state)
            S_IDLE: begin
                if (w_accept && (cmd_period != '0)) begin
                    w_state_nxt = S_RUN;
                    w_cur_nxt   = P_MAX;
                    w_tgt_nxt   = w_clamped;
                    w_dir_nxt   = cmd_dir;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    if (cmd_period == '0) begin
                        w_state_nxt = S_STOPPING;
                    end else if (w_same_dir) begin
                        w_tgt_nxt = w_clamped;
                    end else begin
                        w_state_nxt    = S_REVERSE;
                        w_pend_nxt     = w_clamped;
                        w_pend_dir_nxt = cmd_dir;
                    end
                end
            end
            S_REVERSE: begin
                if (w_terminal && (w_ramped == P_MAX)) begin
                    w_state_nxt = S_RUN;
                    w_dir_nxt   = r_pend_dir;
                    w_tgt_nxt   = r_pend;
                end
            end
            S_STOPPING: begin
                // A fresh nonzero command outranks completing the stop on the same tick.
                if (w_accept && (cmd_period != '0)) begin
                    if (w_same_dir) begin
                        w_state_nxt = S_RUN;
                        w_tgt_nxt   = w_clamped;
                    end else begin
                        w_state_nxt    = S_REVERSE;
                        w_pend_nxt     = w_clamped;
                        w_pend_dir_nxt = cmd_dir;
                    end
                end else if (w_terminal && (w_ramped == P_MAX)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_en_nxt = (w_state_nxt != S_IDLE);
        w_at_nxt = (w_state_nxt == S_RUN) && (w_cur_nxt == w_tgt_nxt);
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_cur      <= P_MAX;
            r_tgt      <= P_MAX;
            r_pend     <= P_MAX;
            r_pend_dir <= 1'b0;
            r_dir      <= 1'b0;
            r_phase    <= 3'd0;
            r_tick     <= 1'b0;
            r_en       <= 1'b0;
            r_at       <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_cur      <= w_cur_nxt;
            r_tgt      <= w_tgt_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_dir <= w_pend_dir_nxt;
            r_dir      <= w_dir_nxt;
            r_phase    <= w_phase_nxt;
            r_tick     <= w_tick_nxt;
            r_en       <= w_en_nxt;
            r_at       <= w_at_nxt;
        end
    end

    assign step_tick  = r_tick;
    assign step_dir   = r_dir;
    assign phase_idx  = r_phase;
    assign motor_en   = r_en;
    assign at_speed   = r_at;
    assign cur_period = r_cur;

endmodule

// File: tb/tb_step_rate_ctrl.sv
// Bench for step_rate_ctrl: directed ramp/reverse/stop scenarios plus random commands,
// all compared every cycle against an interval-countdown model of the scheduler.
module tb_step_rate_ctrl;

    localparam int W    = 8;
    localparam int MINP = 4;
    localparam int MAXP = 20;
    localparam int RS   = 4;

    localparam int MD_IDLE = 0;
    localparam int MD_RUN  = 1;
    localparam int MD_REV  = 2;
    localparam int MD_STOP = 3;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_period;
    logic         cmd_dir;
    logic         step_tick;
    logic         step_dir;
    logic [2:0]   phase_idx;
    logic         motor_en;
    logic         at_speed;
    logic [W-1:0] cur_period;

    step_rate_ctrl #(
        .WIDTH(W), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .RAMP_STEP(RS)
    ) dut (
        .clk_50MHz (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_period(cmd_period),
        .cmd_dir   (cmd_dir),
        .step_tick (step_tick),
        .step_dir  (step_dir),
        .phase_idx (phase_idx),
        .motor_en  (motor_en),
        .at_speed  (at_speed),
        .cur_period(cur_period)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: mode, period being timed, cycles left until the next tick edge.
    int m_mode, m_cur, m_tgt, m_pend, m_pdir, m_dir, m_phase, m_rem;
    int m_tick, m_en, m_at;

    function automatic int clamp_p(input int p);
        if (p < MINP) return MINP;
        if (p > MAXP) return MAXP;
        return p;
    endfunction

    function automatic int toward(input int c, input int g);
        if (c < g) return (c + RS > g) ? g : c + RS;
        if (c > g) return (c - RS < g) ? g : c - RS;
        return c;
    endfunction

    task automatic m_reset();
        m_mode = MD_IDLE; m_cur = MAXP; m_tgt = MAXP; m_pend = MAXP; m_pdir = 0;
        m_dir = 0; m_phase = 0; m_rem = 0; m_tick = 0; m_en = 0; m_at = 0;
    endtask

    task automatic m_step();
        int p, d, goal, nc;
        bit acc, fire;
        acc  = cmd_valid && (m_mode != MD_REV);
        p    = int'(cmd_period);
        d    = int'(cmd_dir);
        goal = (m_mode == MD_RUN) ? m_tgt : MAXP;
        fire = 1'b0;
        nc   = m_cur;
        m_tick = 0;
        if (m_mode != MD_IDLE) begin
            m_rem--;
            if (m_rem == 0) begin
                fire    = 1'b1;
                m_tick  = 1;
                m_phase = (m_phase + ((m_dir != 0) ? 5 : 1)) % 6;
                nc      = toward(m_cur, goal);
                m_rem   = nc;
            end
        end
        case (m_mode)
            MD_IDLE: if (acc && p != 0) begin
                m_mode = MD_RUN; nc = MAXP; m_rem = MAXP; m_tgt = clamp_p(p); m_dir = d;
            end
            MD_RUN: if (acc) begin
                if (p == 0)          m_mode = MD_STOP;
                else if (d == m_dir) m_tgt = clamp_p(p);
                else begin m_mode = MD_REV; m_pend = clamp_p(p); m_pdir = d; end
            end
            MD_REV: if (fire && nc == MAXP) begin
                m_mode = MD_RUN; m_dir = m_pdir; m_tgt = m_pend;
            end
            default: begin
                if (acc && p != 0) begin
                    if (d == m_dir) begin m_mode = MD_RUN; m_tgt = clamp_p(p); end
                    else begin m_mode = MD_REV; m_pend = clamp_p(p); m_pdir = d; end
                end else if (fire && nc == MAXP) begin
                    m_mode = MD_IDLE;
                end
            end
        endcase
        m_cur = nc;
        m_en  = (m_mode != MD_IDLE) ? 1 : 0;
        m_at  = (m_mode == MD_RUN && m_cur == m_tgt) ? 1 : 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else     m_step();
        end
    end

    // Cycle-by-cycle comparison against the model, sampled away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("step_tick",  int'(step_tick),  m_tick);
            chk("step_dir",   int'(step_dir),   m_dir);
            chk("phase_idx",  int'(phase_idx),  m_phase);
            chk("motor_en",   int'(motor_en),   m_en);
            chk("at_speed",   int'(at_speed),   m_at);
            chk("cur_period", int'(cur_period), m_cur);
            chk("cmd_ready",  int'(cmd_ready),  (m_mode != MD_REV) ? 1 : 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("rst_tick",  int'(step_tick),  0);
        chk("rst_en",    int'(motor_en),   0);
        chk("rst_cur",   int'(cur_period), 20);
        chk("rst_phase", int'(phase_idx),  0);
        chk("rst_dir",   int'(step_dir),   0);
        chk("rst_at",    int'(at_speed),   0);
        chk("rst_ready", int'(cmd_ready),  1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic send(input int p, input bit d);
        int n;
        n = 0;
        cmd_valid  = 1'b1;
        cmd_period = W'(p);
        cmd_dir    = d;
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("send_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!step_tick && cyc < 200);
        if (!step_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic wait_at_speed();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!at_speed && n < 500);
        if (!at_speed) chk("at_speed_timeout", 0, 1);
    endtask

    int cyc, nt;
    int s1_iv[5] = '{20, 16, 12, 8, 8};
    int s2_iv[6] = '{12, 16, 20, 16, 12, 8};
    int s2_ph[6] = '{1, 2, 1, 0, 5, 4};

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_period = '0; cmd_dir = 1'b0;
        do_reset();

        // Start from IDLE and ramp 20 -> 8 forward.
        send(8, 1'b0);
        chk("s1_en", int'(motor_en), 1);
        for (int i = 0; i < 5; i++) begin
            wait_tick(cyc);
            chk("s1_interval", cyc, s1_iv[i]);
            chk("s1_phase", int'(phase_idx), i + 1);
            if (i == 1) chk("s1_at_before", int'(at_speed), 0);
            if (i == 2) begin
                chk("s1_at_speed", int'(at_speed), 1);
                chk("s1_model_cur", m_cur, 8);
            end
        end

        // Reversal: decelerate to 20, flip, accelerate back to 8 with wrap 0 -> 5.
        send(8, 1'b1);
        chk("s2_ready_low", int'(cmd_ready), 0);
        wait_tick(cyc);
        chk("s2_partial", cyc, 7);
        chk("s2_phase0", int'(phase_idx), 0);
        for (int i = 0; i < 6; i++) begin
            wait_tick(cyc);
            chk("s2_interval", cyc, s2_iv[i]);
            chk("s2_phase", int'(phase_idx), s2_ph[i]);
            if (i == 0) chk("s2_dir_before", int'(step_dir), 0);
            if (i == 1) begin
                chk("s2_dir_flip", int'(step_dir), 1);
                chk("s2_ready_back", int'(cmd_ready), 1);
            end
        end

        // Stop: decelerate to 20 then drop the drive.
        send(0, 1'b0);
        wait_tick(cyc);
        chk("s3_partial", cyc, 7);
        chk("s3_phase0", int'(phase_idx), 3);
        wait_tick(cyc);
        chk("s3_iv12", cyc, 12);
        wait_tick(cyc);
        chk("s3_iv16", cyc, 16);
        chk("s3_en_off", int'(motor_en), 0);
        nt = 0;
        repeat (60) begin
            @(negedge clk);
            if (step_tick) nt++;
        end
        chk("s3_no_ticks", nt, 0);
        chk("s3_phase_held", int'(phase_idx), 1);

        // Clamping and stop command while idle.
        send(0, 1'b0);
        repeat (30) @(negedge clk);
        chk("s4_idle_stays", int'(motor_en), 0);
        send(1, 1'b0);
        wait_at_speed();
        chk("s4_clamp_min", int'(cur_period), 4);
        send(200, 1'b0);
        chk("s4_not_at", int'(at_speed), 0);
        wait_at_speed();
        chk("s4_clamp_max", int'(cur_period), 20);

        // Target change mid-ramp.
        do_reset();
        send(8, 1'b0);
        wait_tick(cyc);
        wait_tick(cyc);
        chk("s5_cur12", int'(cur_period), 12);
        send(16, 1'b0);
        wait_tick(cyc);
        chk("s5_iv_cur", cyc, 11);
        wait_tick(cyc);
        chk("s5_iv16a", cyc, 16);
        wait_tick(cyc);
        chk("s5_iv16b", cyc, 16);
        chk("s5_at", int'(at_speed), 1);

        // Reset mid-interval while running.
        repeat (5) @(negedge clk);
        do_reset();
        nt = 0;
        repeat (40) begin
            @(negedge clk);
            if (step_tick) nt++;
        end
        chk("s6_no_ticks", nt, 0);

        // Random command traffic, checked against the model every cycle.
        for (int i = 0; i < 15000; i++) begin
            int r;
            @(negedge clk);
            if ($urandom_range(0, 3999) == 0) begin
                do_reset();
            end else begin
                r = int'($urandom_range(0, 9));
                cmd_valid = ($urandom_range(0, 49) == 0);
                cmd_dir   = 1'($urandom_range(0, 1));
                if (r == 0)      cmd_period = '0;
                else if (r == 1) cmd_period = W'($urandom_range(1, 3));
                else if (r == 2) cmd_period = W'($urandom_range(200, 255));
                else             cmd_period = W'($urandom_range(4, 20));
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
